// File: rtl/pc_sequencer.sv
// Fetch PC generator: BOOT/RUN/TRAP control, sequential advance and one-cycle redirects.
// Define PC_RAS_EN to compile in the return-address stack used by mode-11 redirects.
module pc_sequencer #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_mode,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] rs1,
    input  logic            is_call,
    input  logic            trap_ack,
    output logic [XLEN-1:0] pc,
    output logic            fetch_valid,
    output logic            misaligned,
    output logic            ras_empty
);

    // state | meaning
    // BOOT  | just out of reset, pc=RESET_VECTOR, not fetching
    // RUN   | fetching; pc advances or follows redirects
    // TRAP  | misaligned redirect target seen, waiting for trap_ack
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;

    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] ras_top;
    logic            ras_hit;
    logic            ras_empty_w;
    logic            redirect_act;
    logic            target_bad;
    logic            accept;

    assign redirect_act = (state_q == ST_RUN) && redirect_valid && (redirect_mode != 2'b00);
    assign target_bad   = target[1] | target[0];
    assign accept       = redirect_act && !target_bad;

    always_comb begin
        rel_target     = redirect_base + immediate;
        jalr_target    = rs1 + immediate;
        jalr_target[0] = 1'b0;
        if (redirect_mode == 2'b01) begin
            target = rel_target;
        end else if (ras_hit) begin
            target = ras_top;
        end else begin
            target = jalr_target;
        end
    end

`ifdef PC_RAS_EN
    localparam int unsigned     PTR_W    = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]  RAS_FULL = (PTR_W+1)'(RAS_DEPTH);

    logic [XLEN-1:0]  ras_mem_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [PTR_W-1:0] ras_top_idx;
    logic [PTR_W:0]   ras_cnt_q, ras_cnt_d;
    logic [XLEN-1:0]  link_addr;
    logic             ras_pop;
    logic             ras_push;

    // ras_ptr_q is the next free slot; a push on a full stack lands on the oldest entry.
    assign ras_top_idx = ras_ptr_q - 1'b1;
    assign ras_top     = ras_mem_q[ras_top_idx];
    assign ras_hit     = (redirect_mode == 2'b11) && (ras_cnt_q != '0);
    assign ras_empty_w = (ras_cnt_q == '0);
    assign link_addr   = redirect_base + XLEN'(4);
    assign ras_pop     = accept && ras_hit;
    assign ras_push    = accept && is_call;

    always_comb begin
        ras_mem_d = ras_mem_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        if (ras_pop && ras_push) begin
            ras_mem_d[ras_top_idx] = link_addr;
        end else if (ras_pop) begin
            ras_ptr_d = ras_top_idx;
            ras_cnt_d = ras_cnt_q - 1'b1;
        end else if (ras_push) begin
            ras_mem_d[ras_ptr_q] = link_addr;
            ras_ptr_d = ras_ptr_q + 1'b1;
            if (ras_cnt_q != RAS_FULL) begin
                ras_cnt_d = ras_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
            ras_mem_q <= ras_mem_d;
        end
    end
`else
    logic ras_unused;

    assign ras_top     = '0;
    assign ras_hit     = 1'b0;
    assign ras_empty_w = 1'b1;
    assign ras_unused  = is_call;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (redirect_act && target_bad) state_d = ST_TRAP;
            ST_TRAP: if (trap_ack) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // A redirect wins over sequential advance and ignores stall/fetch_ready.
    always_comb begin
        pc_d  = pc_q;
        mis_d = mis_q;
        case (state_q)
            ST_BOOT: pc_d = RESET_VECTOR;
            ST_RUN: begin
                if (accept) begin
                    pc_d = target;
                end else if (redirect_act) begin
                    mis_d = 1'b1;
                end else if (fetch_ready && !stall) begin
                    pc_d = pc_q + XLEN'(4);
                end
            end
            ST_TRAP: if (trap_ack) mis_d = 1'b0;
            default: mis_d = 1'b0;
        endcase
    end

    always_comb begin
        pc          = pc_q;
        fetch_valid = (state_q == ST_RUN);
        misaligned  = mis_q;
        ras_empty   = ras_empty_w;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, sets the PC, immediate and operand width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, sets the PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, sets the return-address-stack entry count (power of 2, at least 2).
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 stall  in  1  holds sequential advance.
REQ-007 fetch_ready  in  1  fetch stage accepts the current pc.
REQ-008 redirect_valid  in  1  control-flow change request this cycle.
REQ-009 redirect_mode  in  2  01 PC-relative, 10 JALR, 11 return; 00 is ignored.
REQ-010 redirect_base  in  XLEN  PC of the redirecting instruction.
REQ-011 immediate  in  XLEN  sign-extended offset.
REQ-012 rs1  in  XLEN  register operand for JALR and return.
REQ-013 is_call  in  1  redirect is a call (push link).
REQ-014 trap_ack  in  1  releases the TRAP state.
REQ-015 pc  out  XLEN  current fetch address.
REQ-016 fetch_valid  out  1  pc is valid for fetch.
REQ-017 misaligned  out  1  misaligned redirect target trapped.
REQ-018 ras_empty  out  1  return stack holds no entries.

Function
REQ-019 FSM states: BOOT, RUN, TRAP; BOOT goes to RUN on the first clock after reset deasserts.
REQ-020 In BOOT, fetch_valid=0 and pc=RESET_VECTOR.
REQ-021 In RUN, fetch_valid=1.
REQ-022 In RUN with no redirect, pc advances to pc+4 only when fetch_ready=1 and stall=0; otherwise pc holds.
REQ-023 A redirect in RUN with mode!=00 takes effect next cycle regardless of stall or fetch_ready.
REQ-024 Redirect targets: mode 01 gives target=redirect_base+immediate; mode 10 gives target=(rs1+immediate) with bit0 cleared.
REQ-025 All adds wrap modulo 2^XLEN; no overflow flag.
REQ-026 If target bit1 or bit0 is 1 after the mode-10 clear, pc holds, the FSM enters TRAP, and misaligned=1 from the next cycle.
REQ-027 In TRAP, fetch_valid=0, pc holds, and redirects are ignored; trap_ack=1 returns the FSM to RUN with misaligned=0 next cycle.
REQ-028 Redirect latency is one cycle: the new pc is visible the cycle after redirect_valid.

Reset
REQ-029 Reset asserted forces, immediately and without waiting for clk: pc=RESET_VECTOR, FSM=BOOT, fetch_valid=0, misaligned=0, RAS pointer and count=0, ras_empty=1.
REQ-030 Reset asserted mid-redirect or during TRAP discards the pending operation.

Configuration
REQ-031 Macro PC_RAS_EN compiles in the return-address stack.
REQ-032 With PC_RAS_EN: an accepted redirect with is_call=1 pushes redirect_base+4; when full, the push overwrites the oldest entry and the count saturates at RAS_DEPTH.
REQ-033 With PC_RAS_EN: mode 11 pops the top entry as the target; if the stack is empty, the target falls back to the mode-10 rule.
REQ-034 With PC_RAS_EN: a call that is also a return (is_call=1, mode 11) pops first, then pushes.
REQ-035 With PC_RAS_EN: a redirect that traps does not modify the RAS.
REQ-036 Without PC_RAS_EN: mode 11 behaves as mode 10, is_call is ignored, and ras_empty is tied to 1.

Verification
REQ-037 Reset with RESET_VECTOR=0x100, then fetch_ready=1 for 3 cycles -> pc reads 0x100 (fetch_valid=0), then 0x100, 0x104, 0x108.
REQ-038 pc=0x20 with stall=1 and redirect mode 01, base=0x20, imm=0xFFFFFFF0 -> pc=0x10 next cycle.
REQ-039 Mode 10, rs1=0x1001, imm=0x2 -> target 0x1002 triggers TRAP, misaligned=1, pc unchanged; trap_ack -> RUN.
REQ-040 PC_RAS_EN, RAS_DEPTH=4: five calls with bases 0x0,0x10,0x20,0x30,0x40, then five returns -> targets 0x44,0x34,0x24,0x14, then the rs1+imm fallback, with ras_empty=1.
REQ-041 pc=0xFFFFFFFC with fetch_ready=1 -> pc=0x0; reset asserted between clock edges -> pc=RESET_VECTOR before the next edge.
